// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module      : wb_port_arbiter
// Description : Write-back port arbiter sharing one register-file write port
//               between the MEM/WB pipeline stage and a multiply/divide unit.
//               The pipeline always wins. A starvation FSM requests a pipeline
//               bubble once the MDU has waited STARVE_LIMIT cycles.
//               Optional macro WBARB_PERF_EN adds the conflict_cnt counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        WBreg,
  input  logic        RegWritereg,
  input  logic [31:0] Memreg,
  input  logic [31:0] ALUreg,
  input  logic [4:0]  RegRDreg,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        stall_req
`ifdef WBARB_PERF_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  localparam logic       c_NORMAL = 1'b0;
  localparam logic       c_STARVE = 1'b1;
  localparam logic [3:0] c_LIMIT  = 4'(STARVE_LIMIT);

  logic       w_pw;
  logic       w_xfer;
  logic       w_mdu_wr;
  logic       w_state_nxt;
  logic       r_state;
  logic       r_stall;
  logic [3:0] r_age;

  // Pipeline write request; writes to r0 are dropped entirely.
  assign w_pw      = RegWritereg && (RegRDreg != 5'd0);
  // MDU is accepted only when the pipeline is not using the port (or rd=0).
  // Held low during reset so no grant can leak out of a reset cycle.
  assign w_xfer    = !rst && mdu_valid && (!w_pw || (mdu_rd == 5'd0));
  assign w_mdu_wr  = w_xfer && (mdu_rd != 5'd0);
  assign mdu_ready = w_xfer;
  assign stall_req = r_stall;

  // Register-file write port: pipeline first, then MDU, else hold address/data.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= 5'd0;
      rf_wd <= 32'd0;
    end else if (w_pw) begin
      rf_we <= 1'b1;
      rf_wa <= RegRDreg;
      rf_wd <= WBreg ? Memreg : ALUreg;
    end else if (w_mdu_wr) begin
      rf_we <= 1'b1;
      rf_wa <= mdu_rd;
      rf_wd <= mdu_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Age of the pending MDU result, saturating at the starvation limit.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_age <= 4'd0;
    end else if (!mdu_valid || w_xfer) begin
      r_age <= 4'd0;
    end else if (r_age < c_LIMIT) begin
      r_age <= r_age + 4'd1;
    end
  end

  // Starvation FSM next state: enter on a saturated age, leave on transfer/flush.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_NORMAL: if ((r_age == c_LIMIT) && mdu_valid && !w_xfer) w_state_nxt = c_STARVE;
      c_STARVE: if (w_xfer || !mdu_valid) w_state_nxt = c_NORMAL;
      default:  w_state_nxt = c_NORMAL;
    endcase
  end

  // State register; stall_req mirrors the registered state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= c_NORMAL;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stall <= (w_state_nxt == c_STARVE);
    end
  end

`ifdef WBARB_PERF_EN
  logic [15:0] r_conflict;
  assign conflict_cnt = r_conflict;

  // Count cycles where both requesters want a real register, saturating.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_conflict <= 16'd0;
    end else if (w_pw && mdu_valid && (mdu_rd != 5'd0) && (r_conflict != 16'hFFFF)) begin
      r_conflict <= r_conflict + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Scoreboard bench for wb_port_arbiter (STARVE_LIMIT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        WBreg = 1'b0, RegWritereg = 1'b0, mdu_valid = 1'b0;
  logic [31:0] Memreg = '0, ALUreg = '0, mdu_data = '0;
  logic [4:0]  RegRDreg = '0, mdu_rd = '0;
  logic        mdu_ready, rf_we, stall_req;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
`ifdef WBARB_PERF_EN
  logic [15:0] conflict_cnt;
`endif

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .rst(rst), .WBreg(WBreg), .RegWritereg(RegWritereg),
    .Memreg(Memreg), .ALUreg(ALUreg), .RegRDreg(RegRDreg),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .stall_req(stall_req)
`ifdef WBARB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic        obs_rdy;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Drive one cycle of inputs, push the expected result, advance past the edge.
  task automatic step(input logic rw, input logic [4:0] rd, input logic wb,
                      input logic [31:0] mem, input logic [31:0] alu,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    logic pw, rdy;
    exp_t x;
    RegWritereg = rw; RegRDreg = rd; WBreg = wb; Memreg = mem; ALUreg = alu;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    pw  = rw && (rd != 5'd0);
    rdy = mv && (!pw || (mrd == 5'd0));
    if (pw) begin
      x.we = 1'b1; x.wa = rd; x.wd = wb ? mem : alu;
    end else if (rdy && (mrd != 5'd0)) begin
      x.we = 1'b1; x.wa = mrd; x.wd = md;
    end else begin
      x.we = 1'b0; x.wa = m_wa; x.wd = m_wd;
    end
    x.rdy = rdy;
    m_wa = x.wa; m_wd = x.wd;
    sb.push_back(x);
    #2 obs_rdy = mdu_ready;
    @(posedge clock); #1;
  endtask

  task automatic release_reset();
    @(posedge clock); #1;
    rst = 1'b0;
    sb.delete();
    m_wa = '0; m_wd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mdu_valid = 1'b1; mdu_rd = 5'd9; RegWritereg = 1'b0;
    #2;
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd, stall_req, mdu_ready} !== 40'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h stall=%b rdy=%b, need all 0",
               rf_we, rf_wa, rf_wd, stall_req, mdu_ready);
    end
    release_reset();
    mdu_valid = 1'b0;
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_err++; $display("FAIL reset_release_we: got %b need 0", rf_we);
    end
  endtask

  task automatic test_pipeline_write();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 5'd5, (i == 0), 32'hDEADBEEF, 32'h0BADF00D, 1'b0, 5'd0, 32'd0);
      e = sb.pop_front();
      n_cmp++;
      if ({rf_we, rf_wa, rf_wd} !== {e.we, e.wa, e.wd}) begin
        n_err++;
        $display("FAIL pipe_write_wb%0d: got we=%b wa=%0d wd=%h need we=%b wa=%0d wd=%h",
                 1 - i, rf_we, rf_wa, rf_wd, e.we, e.wa, e.wd);
      end
    end
  endtask

  task automatic test_mdu_write();
    step(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd9, 32'h12345678);
    e = sb.pop_front();
    n_cmp++;
    if (obs_rdy !== e.rdy) begin
      n_err++; $display("FAIL mdu_ready: got %b need %b", obs_rdy, e.rdy);
    end
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd} !== {e.we, e.wa, e.wd}) begin
      n_err++;
      $display("FAIL mdu_write: got we=%b wa=%0d wd=%h need we=%b wa=%0d wd=%h",
               rf_we, rf_wa, rf_wd, e.we, e.wa, e.wd);
    end
  endtask

  task automatic test_rd_zero();
    // Pipeline to r0 does not block the MDU.
    step(1'b1, 5'd0, 1'b0, 32'd0, 32'h11111111, 1'b1, 5'd7, 32'h77770007);
    e = sb.pop_front();
    n_cmp++;
    if ({obs_rdy, rf_we, rf_wa, rf_wd} !== {e.rdy, e.we, e.wa, e.wd}) begin
      n_err++;
      $display("FAIL pw_rd0: got rdy=%b we=%b wa=%0d wd=%h need rdy=%b we=%b wa=%0d wd=%h",
               obs_rdy, rf_we, rf_wa, rf_wd, e.rdy, e.we, e.wa, e.wd);
    end
    // MDU to r0 is acknowledged but writes nothing, even alongside a pipeline write.
    step(1'b1, 5'd4, 1'b0, 32'd0, 32'h44444444, 1'b1, 5'd0, 32'hFFFFFFFF);
    e = sb.pop_front();
    n_cmp++;
    if ({obs_rdy, rf_we, rf_wa, rf_wd} !== {e.rdy, e.we, e.wa, e.wd}) begin
      n_err++;
      $display("FAIL mdu_rd0_with_pw: got rdy=%b we=%b wa=%0d wd=%h need rdy=%b we=%b wa=%0d wd=%h",
               obs_rdy, rf_we, rf_wa, rf_wd, e.rdy, e.we, e.wa, e.wd);
    end
    step(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    e = sb.pop_front();
    n_cmp++;
    if ({obs_rdy, rf_we} !== 2'b10) begin
      n_err++; $display("FAIL mdu_rd0: got rdy=%b we=%b need rdy=1 we=0", obs_rdy, rf_we);
    end
  endtask

  task automatic test_equal_rd();
    step(1'b1, 5'd3, 1'b1, 32'hAAAA0003, 32'd0, 1'b1, 5'd3, 32'hBBBB0003);
    e = sb.pop_front();
    n_cmp++;
    if ({obs_rdy, rf_we, rf_wa, rf_wd} !== {e.rdy, e.we, e.wa, e.wd}) begin
      n_err++;
      $display("FAIL equal_rd_pw_wins: got rdy=%b wa=%0d wd=%h need rdy=%b wa=%0d wd=%h",
               obs_rdy, rf_wa, rf_wd, e.rdy, e.wa, e.wd);
    end
    step(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd3, 32'hBBBB0003);
    e = sb.pop_front();
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd} !== {e.we, e.wa, e.wd}) begin
      n_err++;
      $display("FAIL equal_rd_mdu_later: got we=%b wa=%0d wd=%h need we=%b wa=%0d wd=%h",
               rf_we, rf_wa, rf_wd, e.we, e.wa, e.wd);
    end
  endtask

  // Pipeline writes every cycle while the MDU waits; stall_req expected from edge 5.
  task automatic ramp(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      step(1'b1, 5'd10, 1'b0, 32'd0, 32'hA0 + 32'(i), 1'b1, 5'd3, 32'h33333333);
      e = sb.pop_front();
      n_cmp++;
      if ({rf_we, rf_wa, rf_wd, obs_rdy, stall_req} !== {e.we, e.wa, e.wd, e.rdy, (i >= 5)}) begin
        n_err++;
        $display("FAIL %s_edge%0d: got we=%b wa=%0d wd=%h rdy=%b stall=%b need we=%b wa=%0d wd=%h rdy=%b stall=%b",
                 tag, i, rf_we, rf_wa, rf_wd, obs_rdy, stall_req, e.we, e.wa, e.wd, e.rdy, (i >= 5));
      end
    end
  endtask

  task automatic test_starve();
    ramp(6, "starve");
    // Bubble supplied: MDU transfers while stall is still up, stall drops after.
    step(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd3, 32'h33333333);
    e = sb.pop_front();
    n_cmp++;
    if ({obs_rdy, rf_we, rf_wa, rf_wd, stall_req} !== {1'b1, 1'b1, 5'd3, 32'h33333333, 1'b0}) begin
      n_err++;
      $display("FAIL starve_bubble: got rdy=%b we=%b wa=%0d wd=%h stall=%b need rdy=1 we=1 wa=3 wd=33333333 stall=0",
               obs_rdy, rf_we, rf_wa, rf_wd, stall_req);
    end
  endtask

  task automatic test_flush();
    ramp(5, "flush");
    step(1'b1, 5'd10, 1'b0, 32'd0, 32'h5, 1'b0, 5'd3, 32'd0);
    e = sb.pop_front();
    n_cmp++;
    if ({stall_req, rf_wa, rf_wd} !== {1'b0, e.wa, e.wd}) begin
      n_err++; $display("FAIL flush_stall: got stall=%b need 0", stall_req);
    end
  endtask

  task automatic test_reset_mid_starve();
    ramp(5, "pre_rst");
    RegWritereg = 1'b1; mdu_valid = 1'b1;
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd, stall_req, mdu_ready} !== 40'd0) begin
      n_err++;
      $display("FAIL mid_starve_reset: got we=%b wa=%0d wd=%h stall=%b rdy=%b need all 0",
               rf_we, rf_wa, rf_wd, stall_req, mdu_ready);
    end
    release_reset();
    n_cmp++;
    if ({rf_we, stall_req} !== 2'b00) begin
      n_err++; $display("FAIL post_reset: got we=%b stall=%b need 0 0", rf_we, stall_req);
    end
    ramp(5, "post_rst");
    step(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    e = sb.pop_front();
  endtask

`ifdef WBARB_PERF_EN
  task automatic test_perf();
    rst = 1'b1; #2;
    release_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd1, 1'b0, 32'd0, 32'd1, 1'b1, 5'd2, 32'd2);
      e = sb.pop_front();
    end
    step(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    e = sb.pop_front();
    n_cmp++;
    if (conflict_cnt !== 16'd3) begin
      n_err++; $display("FAIL conflict_cnt3: got %0d need 3", conflict_cnt);
    end
    RegWritereg = 1'b1; RegRDreg = 5'd1; mdu_valid = 1'b1; mdu_rd = 5'd2;
    repeat (65540) @(posedge clock);
    #1;
    n_cmp++;
    if (conflict_cnt !== 16'hFFFF) begin
      n_err++; $display("FAIL conflict_sat: got %h need ffff", conflict_cnt);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (conflict_cnt !== 16'hFFFF) begin
      n_err++; $display("FAIL conflict_hold: got %h need ffff", conflict_cnt);
    end
  endtask
`endif

  initial begin
    @(posedge clock); #1;
    test_reset();
    test_pipeline_write();
    test_mdu_write();
    test_rd_zero();
    test_equal_rd();
    test_starve();
    test_flush();
    test_reset_mid_starve();
`ifdef WBARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, range 1..15: consecutive cycles the MDU may wait before a stall is requested.
REQ-002 clock  input  1  rising-edge clock; the block's only clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 WBreg  input  1  MEM/WB MemtoReg select: 1 = Memreg, 0 = ALUreg.
REQ-005 RegWritereg  input  1  MEM/WB register-write enable.
REQ-006 Memreg  input  32  MEM/WB load data.
REQ-007 ALUreg  input  32  MEM/WB ALU result.
REQ-008 RegRDreg  input  5  MEM/WB destination register.
REQ-009 mdu_valid  input  1  multiply/divide unit result pending.
REQ-010 mdu_rd  input  5  MDU destination register.
REQ-011 mdu_data  input  32  MDU result.
REQ-012 mdu_ready  output  1  combinational; MDU result accepted this cycle.
REQ-013 rf_we  output  1  registered register-file write enable.
REQ-014 rf_wa  output  5  registered register-file write address.
REQ-015 rf_wd  output  32  registered register-file write data.
REQ-016 stall_req  output  1  registered; requests one pipeline bubble into MEM/WB.

Function
REQ-017 A pipeline write request (PW) SHALL be RegWritereg=1 and RegRDreg!=0; RegRDreg=0 writes are discarded.
REQ-018 PW SHALL always win; the pipeline is never back-pressured combinationally.
REQ-019 mdu_ready SHALL be 1 when mdu_valid=1 and (PW=0 or mdu_rd=0), otherwise 0; transfer = mdu_valid and mdu_ready.
REQ-020 An MDU transfer with mdu_rd=0 SHALL be acknowledged and produce no rf write.
REQ-021 The MDU SHALL hold mdu_valid, mdu_rd and mdu_data stable until transfer; the block does not check this.
REQ-022 Next-cycle rf outputs: if PW, rf_we=1, rf_wa=RegRDreg, rf_wd=(WBreg ? Memreg : ALUreg); else if MDU transfer with mdu_rd!=0, rf_we=1, rf_wa=mdu_rd, rf_wd=mdu_data; else rf_we=0 with rf_wa/rf_wd holding their previous values.
REQ-023 Write latency SHALL be exactly one cycle from the winning request to rf_we.
REQ-024 4-bit age counter: increments (saturating at STARVE_LIMIT) each cycle mdu_valid=1 and mdu_ready=0; clears on MDU transfer or mdu_valid=0.
REQ-025 FSM states NORMAL and STARVE; reset state NORMAL.
REQ-026 NORMAL -> STARVE when age equals STARVE_LIMIT and mdu_valid=1 and no transfer in that cycle; stall_req=1 from the next edge.
REQ-027 In STARVE, stall_req SHALL stay 1 until the cycle in which the MDU transfers; the state and stall_req return to NORMAL/0 on the following edge.
REQ-028 STARVE -> NORMAL also when mdu_valid drops to 0 (MDU flush); age clears.
REQ-029 Pipeline contract: while stall_req=1, upstream inserts a bubble (RegWritereg=0) at MEM/WB; if it does not, PW still wins and stall_req remains asserted.
REQ-030 Simultaneous PW and MDU request with equal nonzero rd: PW SHALL write; the MDU waits and writes later (program order is the MDU's responsibility).

Reset
REQ-031 While rst=1: rf_we=0, rf_wa=0, rf_wd=0, stall_req=0, age=0, state NORMAL, mdu_ready forced to 0.
REQ-032 Reset asserted mid-STARVE or mid-transfer SHALL discard the pending grant; no rf write in the first cycle after reset release.

Configuration
REQ-033 Macro WBARB_PERF_EN defined: output conflict_cnt (16 bit, reset 0) SHALL count cycles with PW=1, mdu_valid=1 and mdu_rd!=0, saturating at 0xFFFF.
REQ-034 Macro WBARB_PERF_EN undefined: the conflict_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 PW rd=5, WBreg=1, Memreg=0xDEADBEEF, no MDU -> next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; WBreg=0 selects ALUreg instead.
REQ-036 MDU valid rd=9, data=0x12345678, PW=0 -> mdu_ready=1 same cycle; next cycle rf_we=1, rf_wa=9, rf_wd=0x12345678.
REQ-037 STARVE_LIMIT=4; PW every cycle with MDU valid rd=3 -> stall_req=1 on edge 5; bubble supplied -> MDU writes rd=3; stall_req=0 one cycle after transfer.
REQ-038 PW with RegRDreg=0 plus MDU rd=7 -> MDU granted same cycle, rf_wa=7; an MDU request with rd=0 -> mdu_ready=1, rf_we=0.
REQ-039 rst pulsed while stall_req=1 and mdu_valid=1 -> all outputs 0 during reset; stall_req=0 and age restarts from 0 after release.
REQ-040 With WBARB_PERF_EN defined: 3 conflict cycles -> conflict_cnt=3; preload at 0xFFFF -> stays 0xFFFF.
